// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, defaults and entry type for the fetch path
package fetch_unit_pkg;
   localparam int INSTR_W = 16;
   localparam int PC_W    = 16;
   localparam logic [PC_W-1:0] PC_STEP          = 16'd2;
   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;
   // Last legal instruction row + 1, shared with the ROM sizing in Parameter.v.
   localparam int row_i   = 15;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch buffer with flush and occupancy count
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= next_ptr(tail);
         if (pop)  head <= next_ptr(head);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[head];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and buffered instruction fetch; optional FETCH_BOUND_CHECK_EN
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    imem_pc,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
`ifdef FETCH_BOUND_CHECK_EN
   ,
   output logic               fault
`endif
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  redirect_target;
   logic [CNT_W-1:0] count;
   logic             room;
   logic             push;
   logic             pop;
   fetch_entry_t     head;
   fetch_entry_t     tail_entry;

   assign redirect_target = redirect_pc & ~PC_W'(1);
   assign room            = count < CNT_W'(DEPTH);
   assign pop             = out_valid && out_ready && !redirect_valid;
   assign tail_entry      = '{pc: pc, instr: imem_instr};

`ifdef FETCH_BOUND_CHECK_EN
   logic in_range;
   assign in_range = pc[PC_W-1:1] < (PC_W-1)'(row_i);
   assign push     = room && !fault && in_range && !redirect_valid;

   // Sticky until reset or a redirect lands back inside the ROM.
   always_ff @(posedge clk) begin
      if (rst)
         fault <= 1'b0;
      else if (redirect_valid) begin
         if (redirect_target[PC_W-1:1] < (PC_W-1)'(row_i)) fault <= 1'b0;
      end else if (room && !fault && !in_range)
         fault <= 1'b1;
   end
`else
   assign push = room && !redirect_valid;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         pc <= RESET_PC;
      else if (redirect_valid)
         pc <= redirect_target;
      else if (push)
         pc <= pc + PC_STEP;
   end

   fetch_fifo #(
      .WIDTH($bits(fetch_entry_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push     (push),
      .push_data(tail_entry),
      .pop      (pop),
      .head_data(head),
      .count    (count)
   );

   assign imem_pc   = pc;
   assign out_valid = count != '0;
   assign out_instr = out_valid ? head.instr : '0;
   assign out_pc    = out_valid ? head.pc : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with queue model; optional FETCH_BOUND_CHECK_EN
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic        out_ready = 1'b1;
   logic [15:0] imem_pc0, imem_instr0, out_instr0, out_pc0;
   logic        out_valid0;
   logic [15:0] imem_pc1, imem_instr1, out_instr1, out_pc1;
   logic        out_valid1;
`ifdef FETCH_BOUND_CHECK_EN
   logic        fault0, fault1;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      logic [31:0] w;
      w = 32'h1111 * (32'(a[4:1]) + 32'd1);
      return w[15:0];
   endfunction

   assign imem_instr0 = rom_word(imem_pc0);
   assign imem_instr1 = rom_word(imem_pc1);

   fetch_unit dut0 (
      .clk(clk), .rst(rst), .imem_pc(imem_pc0), .imem_instr(imem_instr0),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid0), .out_ready(out_ready), .out_instr(out_instr0), .out_pc(out_pc0)
`ifdef FETCH_BOUND_CHECK_EN
      , .fault(fault0)
`endif
   );

   fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
      .clk(clk), .rst(rst), .imem_pc(imem_pc1), .imem_instr(imem_instr1),
      .redirect_valid(1'b0), .redirect_pc(16'h0000),
      .out_valid(out_valid1), .out_ready(1'b1), .out_instr(out_instr1), .out_pc(out_pc1)
`ifdef FETCH_BOUND_CHECK_EN
      , .fault(fault1)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a bounded queue of (pc, instr) plus the fetch PC.
   typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
   ent_t        mq[$];
   logic [15:0] mpc = 16'h0;
   bit          mfault = 1'b0;

   function automatic bit pc_ok(input logic [15:0] p);
`ifdef FETCH_BOUND_CHECK_EN
      return (p >> 1) < 16'd15;
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk) begin
      bit room;
      ent_t e;
      if (rst) begin
         mq.delete(); mpc = 16'h0000; mfault = 1'b0;
      end else if (redirect_valid) begin
         mq.delete();
         mpc = redirect_pc & 16'hFFFE;
         if (pc_ok(mpc)) mfault = 1'b0;
      end else begin
         room = mq.size() < 2;
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (room && !mfault) begin
            if (pc_ok(mpc)) begin
               e.pc = mpc; e.instr = rom_word(mpc);
               mq.push_back(e);
               mpc = mpc + 16'd2;
            end else mfault = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", {31'd0, out_valid0}, {31'd0, mq.size() != 0});
         check("m_pc", {16'd0, out_pc0}, {16'd0, (mq.size() != 0) ? mq[0].pc : 16'h0});
         check("m_instr", {16'd0, out_instr0}, {16'd0, (mq.size() != 0) ? mq[0].instr : 16'h0});
         check("m_imem_pc", {16'd0, imem_pc0}, {16'd0, mpc});
`ifdef FETCH_BOUND_CHECK_EN
         check("m_fault", {31'd0, fault0}, {31'd0, mfault});
`endif
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pin(input string name, input bit v, input logic [15:0] p, input logic [15:0] i);
      check({name, "_valid"}, {31'd0, out_valid0}, {31'd0, v});
      check({name, "_pc"}, {16'd0, out_pc0}, {16'd0, p});
      check({name, "_instr"}, {16'd0, out_instr0}, {16'd0, i});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Streaming with decode always ready.
      rst = 1'b1; out_ready = 1'b1;
      step(); step();
      chk_en = 1'b1;
      pin("reset", 1'b0, 16'h0, 16'h0);
      check("reset_imem_pc", {16'd0, imem_pc0}, 32'h0);
      rst = 1'b0;
      pin("c1", 1'b0, 16'h0, 16'h0);
      step(); pin("c2", 1'b1, 16'h0000, 16'h1111);
`ifndef FETCH_BOUND_CHECK_EN
      check("wrap_c2_pc", {16'd0, out_pc1}, 32'hFFFE);
      check("wrap_c2_instr", {16'd0, out_instr1}, 32'h1110);
`endif
      step(); pin("c3", 1'b1, 16'h0002, 16'h2222);
`ifndef FETCH_BOUND_CHECK_EN
      check("wrap_c3_pc", {16'd0, out_pc1}, 32'h0000);
      check("wrap_c3_instr", {16'd0, out_instr1}, 32'h1111);
`endif
      step(); pin("c4", 1'b1, 16'h0004, 16'h3333);
      step(); pin("c5", 1'b1, 16'h0006, 16'h4444);

      // Backpressure saturates the buffer, then drains in order.
      rst = 1'b1; out_ready = 1'b0;
      step();
      rst = 1'b0;
      repeat (5) step();
      check("full_imem_pc", {16'd0, imem_pc0}, 32'h0004);
      pin("full_head", 1'b1, 16'h0000, 16'h1111);
      out_ready = 1'b1;
      step(); pin("drain1", 1'b1, 16'h0002, 16'h2222);
      step(); pin("drain2", 1'b1, 16'h0004, 16'h3333);
      step(); pin("drain3", 1'b1, 16'h0006, 16'h4444);

      // Redirect while full; odd target is aligned down.
      out_ready = 1'b0;
      step();
      redirect_valid = 1'b1; redirect_pc = 16'h0009;
      step();
      redirect_valid = 1'b0;
      check("redir_imem_pc", {16'd0, imem_pc0}, 32'h0008);
      pin("redir_flush", 1'b0, 16'h0, 16'h0);
      step(); pin("redir_first", 1'b1, 16'h0008, 16'h5555);

      // Redirect coinciding with a completed handshake.
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 16'h0002;
      step();
      redirect_valid = 1'b0;
      pin("rpop_gap", 1'b0, 16'h0, 16'h0);
      step(); pin("rpop_first", 1'b1, 16'h0002, 16'h2222);

`ifdef FETCH_BOUND_CHECK_EN
      begin
         logic [15:0] last_pc;
         last_pc = 16'hDEAD;
         redirect_valid = 1'b1; redirect_pc = 16'h0000;
         step();
         redirect_valid = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (fault0) break;
            step();
            if (out_valid0) last_pc = out_pc0;
         end
         check("bound_fault", {31'd0, fault0}, 32'd1);
         check("bound_last_pc", {16'd0, last_pc}, 32'd28);
         step(); step();
         check("bound_pc_hold", {16'd0, imem_pc0}, 32'd30);
         pin("bound_empty", 1'b0, 16'h0, 16'h0);
         redirect_valid = 1'b1; redirect_pc = 16'h0000;
         step();
         redirect_valid = 1'b0;
         check("bound_clear", {31'd0, fault0}, 32'd0);
         step(); pin("bound_resume", 1'b1, 16'h0000, 16'h1111);
      end
`endif

      repeat (3) step();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Drives `imem_pc` to the instruction ROM and captures the returned 16-bit instruction.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Redirects the PC on branch/jump, flushing stale entries.
- Sits between the PC logic and decode; ROM read is combinational and word-indexed by `pc[4:1]`.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset; bit 0 must be 0.
- `DEPTH`, default 2: fetch buffer entries, minimum 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_pc`  out  16  fetch address to instruction ROM; equals PC register.
- `imem_instr`  in  16  ROM data for `imem_pc`, valid the same cycle.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  16  new PC; bit 0 forced to 0.
- `out_valid`  out  1  buffer head valid.
- `out_ready`  in  1  decode accepts head.
- `out_instr`  out  16  head instruction; 16'h0000 when `out_valid`=0.
- `out_pc`  out  16  head PC; 16'h0000 when `out_valid`=0.
- `fault`  out  1  sticky out-of-range fetch flag; present only with `FETCH_BOUND_CHECK_EN`.

## Operation
**State**
- PC register (16 bits).
- FIFO of {pc, instr}, `DEPTH` entries, with count 0..DEPTH.

**Reset values**
- PC = `RESET_PC`; count = 0.
- `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0.

**Per cycle, when `redirect_valid`=0**
- pop = `out_valid` & `out_ready`.
- push = (registered count < DEPTH) & !`fault`.
- On push, write {PC, `imem_instr`} at tail and set PC <= PC + 2.
- Push and pop may occur in the same cycle; count is unchanged.

**Redirect**
- When `redirect_valid`=1: count <= 0 (flush), PC <= {`redirect_pc`[15:1],1'b0}, no push.
- A handshake completing in the redirect cycle counts as accepted by decode; the entry is dropped by the flush regardless.
- Redirect has priority over push and pop.

**Arithmetic and boundaries**
- PC increment is modulo 2^16: 16'hFFFE + 2 = 16'h0000.
- When full (count = DEPTH): no push and PC holds, even if a pop happens that cycle. A pop frees a slot for the next cycle.
- When empty: `out_valid`=0, and `out_ready` is ignored.
- Reset asserted mid-operation overrides redirect, push and pop; the next cycle starts from the reset values.

## Timing
- Redirect at cycle N:
  - `imem_pc` = new PC in cycle N+1.
  - That instruction reaches `out_valid`=1 in cycle N+2.
- After reset, first `out_valid`=1 is in cycle 2, counting the first cycle with `rst`=0 as cycle 1.
- With `out_ready` held high: one instruction per cycle, steady-state count = 1.
- Outputs are registered from FIFO state; there is no combinational path from `out_ready` or `redirect_valid` to outputs.

## Configuration
- `FETCH_BOUND_CHECK_EN` defined:
  - If PC[15:1] >= `row_i` when a push would occur, the push is suppressed and `fault` <= 1.
  - `fault` is sticky and blocks further pushes.
  - Cleared by `rst`, or by a redirect to an in-range PC, which clears `fault` the same edge.
  - Already-buffered entries still drain.
- Undefined: no `fault` port and no range check; the PC wraps freely.

## Structure
- Shared package/include: `INSTR_W`=16, `PC_W`=16, `PC_STEP`=2, default `RESET_PC`. Reuse `row_i` from `Parameter.v`.
- One sub-module, `fetch_fifo`: synchronous FIFO of width `PC_W`+`INSTR_W`, depth `DEPTH`, with flush input and count output.
- PC register, push/pop control and bound check stay in `fetch_unit`.

## Test plan
- Reset, `out_ready`=1, ROM words 0..3 = 16'h1111/2222/3333/4444 -> one valid per cycle with (`out_pc`, `out_instr`) = (0,1111), (2,2222), (4,3333), (6,4444).
- `out_ready`=0 for 5 cycles after reset -> count saturates at 2, `imem_pc` holds at 4. Raise `out_ready` -> pc 0, 2, 4 delivered in order, nothing lost or duplicated.
- Redirect to 16'h0009 while buffer full -> flush, `imem_pc`=16'h0008 next cycle, first output after redirect is `out_pc`=8.
- Redirect and pop in the same cycle -> `out_valid`=0 the next cycle, then `out_pc`=redirect target.
- `RESET_PC`=16'hFFFE, macro off -> outputs `out_pc` FFFE then 0000.
- Macro on, `row_i`=15, sequential run -> last push at `out_pc`=28, `fault`=1 at pc 30. Redirect to 0 clears `fault` and fetch resumes.
